plab5_mcore_dma_scheduler: RTL and testbench
============================================

Name: plab5_mcore_dma_scheduler

Overview:
Shares the single DMA controller copy port between p_num_req core-side requesters.
- Arbitration is round-robin. The winner's command is latched and issued to the DMA, and the scheduler waits for the DMA's ack before routing it back to the winner.
- Enforces a security-domain switch gap: a fixed number of idle cycles whenever consecutive grants change domain.
- Sits between the cores' DMA request ports and the DMA controller's val/rdy/domain/src_addr/dest_addr/ack port.

Parameters:
- p_num_req, 4, number of requesters (2..8).
- p_addr_nbits, 32, address width.
- p_switch_cycles, 2, idle cycles inserted on a domain change (1..15).
- p_timeout, 1024, BUSY watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_val  in  p_num_req  per-requester request valid; held until req_rdy.
- req_rdy  out  p_num_req  one-hot accept strobe.
- req_domain  in  p_num_req  per-requester security level.
- req_src_addr  in  p_num_req*p_addr_nbits  packed source addresses; requester i occupies bits [i*a +: a].
- req_dest_addr  in  p_num_req*p_addr_nbits  packed destination addresses, same packing.
- req_ack  out  p_num_req  one-cycle completion pulse to the owner.
- req_err  out  1  qualifies req_ack as an aborted operation.
- dma_val  out  1  command valid to the DMA.
- dma_rdy  in  1  DMA idle/ready.
- dma_domain  out  1  latched domain.
- dma_src_addr  out  p_addr_nbits  latched source address.
- dma_dest_addr  out  p_addr_nbits  latched destination address.
- dma_ack  in  1  DMA completion pulse.
- busy  out  1  high in every state except IDLE.
- grant_id  out  clog2(p_num_req)  current or last owner.

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr=0, last_domain=0, command registers 0, counters 0.
- Reset asserted mid-operation:
  - Immediate return to IDLE; no req_ack is generated.
  - An in-flight DMA operation is abandoned; the DMA shares the reset.
- IDLE:
  - Winner = first i with req_val[i]=1, searching from rr_ptr upward modulo p_num_req.
  - req_rdy[winner]=1 combinationally in the same cycle. The handshake latches src, dest, domain and grant_id.
  - If the latched domain differs from last_domain, go to SWITCH; otherwise go to ISSUE.
  - No req_val set: stay in IDLE, all req_rdy=0.
- SWITCH:
  - Counter loads p_switch_cycles-1 and decrements to 0; go to ISSUE when it reaches 0.
  - dma_val=0 throughout.
- ISSUE:
  - dma_val=1 with the latched fields; wait for dma_rdy.
  - On dma_val&&dma_rdy, go to BUSY. The fields stay stable until the handshake.
- BUSY:
  - Wait for dma_ack, then go to DONE.
  - A dma_ack seen in any state other than BUSY is ignored.
- DONE (1 cycle):
  - req_ack[grant_id]=1, req_err=0.
  - last_domain <= latched domain; rr_ptr <= (grant_id+1) mod p_num_req; go to IDLE.
- Latency, no switch, DMA ready: handshake in cycle 0, dma_val in cycle 1, req_ack 1 cycle after dma_ack.
- Fairness: a requester held valid is granted within p_num_req completed operations.
- The owner may assert a new req_val during BUSY. It is not accepted until the next IDLE, and rr_ptr puts it last in the search order.
- req_rdy is never asserted outside IDLE.

Optional Feature:
PLAB5_MCORE_DMA_SCHED_TIMEOUT_EN
- Defined:
  - A watchdog counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches p_timeout-1 with no dma_ack, go to DONE with req_err=1 alongside req_ack.
  - last_domain and rr_ptr update as normal.
- Undefined: no counter; req_err tied to 0; BUSY waits indefinitely.

Decomposition:
- Shared package/header holds:
  - State encodings: IDLE=0, SWITCH=1, ISSUE=2, BUSY=3, DONE=4 (3 bits).
  - A clog2 macro for the grant_id width.
- One natural sub-module, plab5_mcore_rr_arbiter: combinational rotating-priority arbiter (req vector, rr_ptr) -> one-hot grant plus index. It is reusable for other shared mcore resources.
- FSM, counters and latches stay in the top module.

Test Plan:
- Single request: req_val[2]=1, domain 0, src=0x1000, dest=0x2000, dma_rdy=1.
  - req_rdy[2] in cycle 0; dma_val in cycle 1 with src=0x1000, dest=0x2000.
  - dma_ack at cycle 5 -> req_ack[2] at cycle 6; grant_id=2; rr_ptr=3.
- Contention: all four req_val held, all domain 0, DMA acks 3 cycles after accept.
  - Grants in order 0,1,2,3,0.
  - Exactly one req_rdy per accept; never two bits set.
- Domain switch: req0 domain 0 completes, then req1 domain 1, p_switch_cycles=2.
  - Exactly 2 SWITCH cycles with dma_val=0 before dma_val rises.
  - A second consecutive domain-1 request has no gap.
- Backpressure: dma_rdy=0 for 4 cycles in ISSUE.
  - dma_val stays 1 with stable fields; handshake on the first dma_rdy=1 cycle.
  - Stray dma_ack during ISSUE is ignored.
- Reset mid-BUSY: pull reset low for 1 cycle.
  - All outputs 0 asynchronously (before the next clk edge); no req_ack.
  - rr_ptr=0; next request re-arbitrates from requester 0.
- Timeout (macro on, p_timeout=16): dma_ack never arrives.
  - req_ack with req_err=1 on the 17th cycle after BUSY entry; next request proceeds normally.

Source files
------------

// File: rtl/plab5_mcore_dma_scheduler_pkg.sv
// Shared definitions for the mcore DMA scheduler: FSM state encoding, the
// grant-index width macro and the round-robin pointer helper.
// Optional feature macro: PLAB5_MCORE_DMA_SCHED_TIMEOUT_EN (BUSY watchdog).
`ifndef PLAB5_MCORE_DMA_SCHEDULER_PKG_SV
`define PLAB5_MCORE_DMA_SCHEDULER_PKG_SV

// Index width for an n-entry one-hot vector; never narrower than one bit.
`define PLAB5_CLOG2(n) (((n) <= 1) ? 1 : $clog2(n))

package plab5_mcore_dma_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SWITCH = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_BUSY   = 3'd3,
        ST_DONE   = 3'd4
    } sched_state_e;

    // Wide enough for the largest domain-switch gap (15 cycles).
    localparam int unsigned SWITCH_CNT_NBITS = 4;

    // Next search start after idx has been served, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`endif

// File: rtl/plab5_mcore_dma_scheduler_if.sv
// Bundle of the core-side request ports and the DMA command port.
// master: the scheduler's view.  slave: the cores + DMA environment's view.
interface plab5_mcore_dma_scheduler_if #(
    parameter int p_num_req    = 4,
    parameter int p_addr_nbits = 32
);
    // Core-side request ports, one bit / slice per requester
    logic [p_num_req-1:0]              req_val;
    logic [p_num_req-1:0]              req_rdy;
    logic [p_num_req-1:0]              req_domain;
    logic [p_num_req*p_addr_nbits-1:0] req_src_addr;
    logic [p_num_req*p_addr_nbits-1:0] req_dest_addr;
    logic [p_num_req-1:0]              req_ack;
    logic                              req_err;

    // Single DMA controller command port
    logic                              dma_val;
    logic                              dma_rdy;
    logic                              dma_domain;
    logic [p_addr_nbits-1:0]           dma_src_addr;
    logic [p_addr_nbits-1:0]           dma_dest_addr;
    logic                              dma_ack;

    modport master (
        input  req_val, req_domain, req_src_addr, req_dest_addr, dma_rdy, dma_ack,
        output req_rdy, req_ack, req_err, dma_val, dma_domain, dma_src_addr, dma_dest_addr
    );

    modport slave (
        output req_val, req_domain, req_src_addr, req_dest_addr, dma_rdy, dma_ack,
        input  req_rdy, req_ack, req_err, dma_val, dma_domain, dma_src_addr, dma_dest_addr
    );
endinterface

// File: rtl/plab5_mcore_rr_arbiter.sv
// Combinational rotating-priority arbiter: the first requester at or above
// ptr_i (wrapping) wins. Reusable for any shared mcore resource.
module plab5_mcore_rr_arbiter #(
    parameter  int p_num_req   = 4,
    localparam int c_idx_nbits = `PLAB5_CLOG2(p_num_req)
) (
    input  logic [p_num_req-1:0]   req_i,
    input  logic [c_idx_nbits-1:0] ptr_i,
    output logic [p_num_req-1:0]   gnt_o,
    output logic [c_idx_nbits-1:0] idx_o,
    output logic                   any_o
);

    logic [c_idx_nbits-1:0] pos;
    logic                   found;

    // Walk the requesters in priority order and keep the first valid one.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < p_num_req; k++) begin
            pos = c_idx_nbits'((int'(ptr_i) + k) % p_num_req);
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = pos;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/plab5_mcore_dma_scheduler.sv
// Shares one DMA copy port between p_num_req cores: round-robin grant,
// command latch, security-domain switch gap, completion routing.
// Optional feature macro: PLAB5_MCORE_DMA_SCHED_TIMEOUT_EN -- BUSY watchdog
// that aborts a stuck operation and reports it on req_err.
module plab5_mcore_dma_scheduler
    import plab5_mcore_dma_scheduler_pkg::*;
#(
    parameter  int p_num_req       = 4,
    parameter  int p_addr_nbits    = 32,
    parameter  int p_switch_cycles = 2,
    parameter  int p_timeout       = 1024,
    localparam int c_id_nbits      = `PLAB5_CLOG2(p_num_req)
) (
    input  logic                  clk,
    input  logic                  reset,
    plab5_mcore_dma_scheduler_if.master bus,
    output logic                  busy,
    output logic [c_id_nbits-1:0] grant_id
);

    if (p_num_req < 2 || p_num_req > 8 || p_switch_cycles < 1 ||
        p_switch_cycles > 15 || p_timeout < 2) begin : g_param_check
        $error("plab5_mcore_dma_scheduler: parameter out of range");
    end

    sched_state_e                state_q, state_d;
    logic [c_id_nbits-1:0]       rr_ptr_q, rr_ptr_d;
    logic                        last_dom_q, last_dom_d;
    logic                        dom_q, dom_d;
    logic [p_addr_nbits-1:0]     src_q, src_d;
    logic [p_addr_nbits-1:0]     dest_q, dest_d;
    logic [c_id_nbits-1:0]       gid_q, gid_d;
    logic [SWITCH_CNT_NBITS-1:0] sw_cnt_q, sw_cnt_d;

`ifdef PLAB5_MCORE_DMA_SCHED_TIMEOUT_EN
    localparam int c_wdog_nbits = `PLAB5_CLOG2(p_timeout);
    localparam logic [c_wdog_nbits-1:0] c_wdog_last = c_wdog_nbits'(p_timeout - 1);
    logic [c_wdog_nbits-1:0] wdog_q, wdog_d;
    logic                    err_q, err_d;
`endif

    logic [p_num_req-1:0]  arb_gnt;
    logic [c_id_nbits-1:0] arb_idx;
    logic                  arb_any;

    plab5_mcore_rr_arbiter #(.p_num_req(p_num_req)) u_arb (
        .req_i (bus.req_val),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Next-state, command latch inputs and handshake outputs.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        last_dom_d = last_dom_q;
        dom_d      = dom_q;
        src_d      = src_q;
        dest_d     = dest_q;
        gid_d      = gid_q;
        sw_cnt_d   = sw_cnt_q;
`ifdef PLAB5_MCORE_DMA_SCHED_TIMEOUT_EN
        wdog_d     = wdog_q;
        err_d      = err_q;
`endif
        bus.req_rdy = '0;
        bus.req_ack = '0;
        bus.dma_val = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Held off while reset is asserted so every output reads 0.
                if (arb_any && reset) begin
                    bus.req_rdy = arb_gnt;
                    dom_d       = bus.req_domain[arb_idx];
                    src_d       = bus.req_src_addr[int'(arb_idx)*p_addr_nbits +: p_addr_nbits];
                    dest_d      = bus.req_dest_addr[int'(arb_idx)*p_addr_nbits +: p_addr_nbits];
                    gid_d       = arb_idx;
                    sw_cnt_d    = SWITCH_CNT_NBITS'(p_switch_cycles - 1);
`ifdef PLAB5_MCORE_DMA_SCHED_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                    state_d     = (bus.req_domain[arb_idx] != last_dom_q) ? ST_SWITCH : ST_ISSUE;
                end
            end
            ST_SWITCH: begin
                if (sw_cnt_q == '0) begin
                    state_d = ST_ISSUE;
                end else begin
                    sw_cnt_d = sw_cnt_q - 1'b1;
                end
            end
            ST_ISSUE: begin
                bus.dma_val = 1'b1;
                if (bus.dma_rdy) begin
                    state_d = ST_BUSY;
`ifdef PLAB5_MCORE_DMA_SCHED_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (bus.dma_ack) begin
                    state_d = ST_DONE;
`ifdef PLAB5_MCORE_DMA_SCHED_TIMEOUT_EN
                end else if (wdog_q == c_wdog_last) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    wdog_d  = wdog_q + 1'b1;
`endif
                end
            end
            ST_DONE: begin
                bus.req_ack[gid_q] = 1'b1;
                last_dom_d         = dom_q;
                rr_ptr_d           = c_id_nbits'(rr_next(gid_q, p_num_req));
                state_d            = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, arbitration history and latched command registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            last_dom_q <= 1'b0;
            dom_q      <= 1'b0;
            src_q      <= '0;
            dest_q     <= '0;
            gid_q      <= '0;
            sw_cnt_q   <= '0;
`ifdef PLAB5_MCORE_DMA_SCHED_TIMEOUT_EN
            wdog_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge value of its peers.
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            last_dom_q <= last_dom_d;
            dom_q      <= dom_d;
            src_q      <= src_d;
            dest_q     <= dest_d;
            gid_q      <= gid_d;
            sw_cnt_q   <= sw_cnt_d;
`ifdef PLAB5_MCORE_DMA_SCHED_TIMEOUT_EN
            wdog_q     <= wdog_d;
            err_q      <= err_d;
`endif
        end
    end

    // The DMA sees the latched command directly; dma_val qualifies it.
    assign bus.dma_domain    = dom_q;
    assign bus.dma_src_addr  = src_q;
    assign bus.dma_dest_addr = dest_q;
    assign busy              = (state_q != ST_IDLE);
    assign grant_id          = gid_q;

`ifdef PLAB5_MCORE_DMA_SCHED_TIMEOUT_EN
    assign bus.req_err = (state_q == ST_DONE) && err_q;
`else
    assign bus.req_err = 1'b0;
`endif

endmodule

// File: tb/tb_plab5_mcore_dma_scheduler.sv
// Self-checking bench for plab5_mcore_dma_scheduler (4 requesters, 32-bit
// addresses, 2-cycle domain gap, watchdog limit 16 when
// PLAB5_MCORE_DMA_SCHED_TIMEOUT_EN is defined).
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_plab5_mcore_dma_scheduler;

    localparam int N  = 4;
    localparam int A  = 32;
    localparam int SW = 2;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic [1:0] grant_id;

    plab5_mcore_dma_scheduler_if #(.p_num_req(N), .p_addr_nbits(A)) bus ();

    plab5_mcore_dma_scheduler #(
        .p_num_req(N), .p_addr_nbits(A), .p_switch_cycles(SW), .p_timeout(TO)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Poll up to 20 cycles for an accept strobe; returns 0 if none came.
    task automatic wait_rdy(output logic [3:0] rdy);
        rdy = '0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req_rdy != '0) begin
                rdy = bus.req_rdy;
                return;
            end
            @(negedge clk);
        end
    endtask

    // One complete operation for requester id: expected gap before dma_val,
    // 'stall' cycles of dma_rdy=0 in ISSUE (stray dma_ack in the second one),
    // two BUSY cycles, DONE, back to IDLE.
    task automatic run_op(input int id, input logic dom, input logic [31:0] src,
                          input logic [31:0] dest, input logic [3:0] extra,
                          input int exp_gap, input int stall);
        logic [3:0] rdy;
        int         gap;
        @(negedge clk);
        bus.req_src_addr[id*A +: A]  = src;
        bus.req_dest_addr[id*A +: A] = dest;
        bus.req_domain[id]           = dom;
        bus.req_val                  = (4'b0001 << id) | extra;
        bus.dma_rdy                  = (stall == 0);
        bus.dma_ack                  = 1'b0;
        wait_rdy(rdy);
        check("op_rdy", rdy, 4'b0001 << id);
        @(negedge clk);
        bus.req_val = '0;
        #1;
        gap = 0;
        while (bus.dma_val !== 1'b1 && gap < 20) begin
            check("gap_busy", busy, 1'b1);
            gap++;
            @(negedge clk);
            #1;
        end
        check("gap_len", gap, exp_gap);
        for (int s = 0; s <= stall; s++) begin
            check("iss_val", bus.dma_val, 1'b1);
            check("iss_src", bus.dma_src_addr, src);
            check("iss_dest", bus.dma_dest_addr, dest);
            check("iss_dom", bus.dma_domain, dom);
            check("iss_gid", grant_id, id);
            if (s < stall) begin
                @(negedge clk);
                bus.dma_rdy = (s + 1 == stall);
                bus.dma_ack = (s == 0) && (stall >= 2);
                #1;
            end
        end
        @(negedge clk);
        bus.dma_ack = 1'b0;
        bus.dma_rdy = 1'b1;
        #1;
        check("busy1_val", bus.dma_val, 1'b0);
        check("busy1_busy", busy, 1'b1);
        check("busy1_ack", bus.req_ack, 4'b0000);
        @(negedge clk);
        bus.dma_ack = 1'b1;
        #1;
        check("busy2_ack", bus.req_ack, 4'b0000);
        @(negedge clk);
        bus.dma_ack = 1'b0;
        #1;
        check("done_ack", bus.req_ack, 4'b0001 << id);
        check("done_err", bus.req_err, 1'b0);
        check("done_rdy", bus.req_rdy, 4'b0000);
        @(negedge clk);
        #1;
        check("idle_busy", busy, 1'b0);
        check("idle_ack", bus.req_ack, 4'b0000);
    endtask

    typedef struct {
        logic [3:0]  req_val;
        logic        dma_rdy;
        logic        dma_ack;
        logic [3:0]  exp_rdy;
        logic        exp_dval;
        logic [3:0]  exp_ack;
        logic        exp_busy;
        logic [1:0]  exp_gid;
        logic [31:0] exp_src;
        logic [31:0] exp_dest;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [3:0] rdy;
        logic [3:0] ack_seen;
        logic       busy_all;
        int         n;

        // Single request from requester 2, then requester 3 wins from rr_ptr=3.
        tbl[0]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0,    32'h0};
        tbl[1]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 32'h1000, 32'h2000};
        tbl[2]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 32'h1000, 32'h2000};
        tbl[3]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 32'h1000, 32'h2000};
        tbl[4]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 32'h1000, 32'h2000};
        tbl[5]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 32'h1000, 32'h2000};
        tbl[6]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2, 32'h1000, 32'h2000};
        tbl[7]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 32'h1000, 32'h2000};
        tbl[8]  = '{4'b1011, 1'b1, 1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd2, 32'h1000, 32'h2000};
        tbl[9]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 32'h3000, 32'h4000};
        tbl[10] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3, 32'h3000, 32'h4000};
        tbl[11] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'd3, 32'h3000, 32'h4000};
        tbl[12] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 32'h3000, 32'h4000};

        reset             = 1'b0;
        bus.req_val       = 4'b0001;
        bus.req_domain    = '0;
        bus.dma_rdy       = 1'b0;
        bus.dma_ack       = 1'b0;
        bus.req_src_addr  = {32'h3000, 32'h1000, 32'h0A10, 32'h0A00};
        bus.req_dest_addr = {32'h4000, 32'h2000, 32'h0B10, 32'h0B00};

        // Reset state (a request pending during reset is not accepted)
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_gid", grant_id, 2'd0);
        check("rst_rdy", bus.req_rdy, 4'b0000);
        check("rst_dval", bus.dma_val, 1'b0);
        check("rst_ack", bus.req_ack, 4'b0000);
        check("rst_src", bus.dma_src_addr, 32'h0);
        @(negedge clk);
        bus.req_val = '0;
        reset       = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            bus.req_val = tbl[i].req_val;
            bus.dma_rdy = tbl[i].dma_rdy;
            bus.dma_ack = tbl[i].dma_ack;
            #1;
            check($sformatf("t%0d_rdy", i), bus.req_rdy, tbl[i].exp_rdy);
            check($sformatf("t%0d_dval", i), bus.dma_val, tbl[i].exp_dval);
            check($sformatf("t%0d_ack", i), bus.req_ack, tbl[i].exp_ack);
            check($sformatf("t%0d_err", i), bus.req_err, 1'b0);
            check($sformatf("t%0d_busy", i), busy, tbl[i].exp_busy);
            check($sformatf("t%0d_gid", i), grant_id, tbl[i].exp_gid);
            check($sformatf("t%0d_src", i), bus.dma_src_addr, tbl[i].exp_src);
            check($sformatf("t%0d_dest", i), bus.dma_dest_addr, tbl[i].exp_dest);
        end

        // Contention: all four held, grants rotate 0,1,2,3,0
        @(negedge clk);
        bus.req_val = 4'b1111;
        bus.dma_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_rdy(rdy);
            check($sformatf("cont%0d_rdy", k), rdy, 4'b0001 << (k % 4));
            @(negedge clk);
            #1;
            check($sformatf("cont%0d_issue", k), bus.dma_val, 1'b1);
            check($sformatf("cont%0d_nordy", k), bus.req_rdy, 4'b0000);
            repeat (2) @(negedge clk);
            @(negedge clk);
            bus.dma_ack = 1'b1;
            #1;
            @(negedge clk);
            bus.dma_ack = 1'b0;
            #1;
            check($sformatf("cont%0d_ack", k), bus.req_ack, 4'b0001 << (k % 4));
            check($sformatf("cont%0d_gid", k), grant_id, k % 4);
            @(negedge clk);
        end
        bus.req_val = '0;
        #1;
        check("cont_idle", busy, 1'b0);

        // Domain switch: 0 -> 1 costs two idle cycles, 1 -> 1 costs none
        run_op(0, 1'b0, 32'h0A00, 32'h0B00, 4'b0000, 0, 0);
        run_op(1, 1'b1, 32'h5000, 32'h6000, 4'b0000, SW, 0);
        run_op(1, 1'b1, 32'h5100, 32'h6100, 4'b0000, 0, 0);

        // Backpressure: four ISSUE cycles with dma_rdy=0 and a stray dma_ack
        run_op(2, 1'b1, 32'h7000, 32'h8000, 4'b0000, 0, 4);
        run_op(3, 1'b0, 32'h7100, 32'h8100, 4'b0000, SW, 0);
        run_op(1, 1'b1, 32'h7200, 32'h8200, 4'b0000, SW, 0);

        // Reset in BUSY (rr_ptr=2, last_domain=1 beforehand)
        @(negedge clk);
        bus.req_domain[2] = 1'b1;
        bus.req_val       = 4'b0100;
        bus.dma_rdy       = 1'b1;
        wait_rdy(rdy);
        check("rb_rdy", rdy, 4'b0100);
        @(negedge clk);
        bus.req_val = '0;
        #1;
        check("rb_issue", bus.dma_val, 1'b1);
        @(negedge clk);
        #1;
        check("rb_busy", busy, 1'b1);
        @(negedge clk);
        reset       = 1'b0;
        bus.req_val = 4'b0010;
        #1;
        check("ra_busy", busy, 1'b0);
        check("ra_dval", bus.dma_val, 1'b0);
        check("ra_gid", grant_id, 2'd0);
        check("ra_rdy", bus.req_rdy, 4'b0000);
        check("ra_ack", bus.req_ack, 4'b0000);
        check("ra_err", bus.req_err, 1'b0);
        check("ra_dom", bus.dma_domain, 1'b0);
        check("ra_addr", {bus.dma_src_addr, bus.dma_dest_addr}, 64'h0);
        @(negedge clk);
        bus.req_val = '0;
        reset       = 1'b1;
        bus.dma_ack = 1'b1;
        ack_seen    = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            ack_seen |= bus.req_ack;
            @(negedge clk);
            bus.dma_ack = 1'b0;
        end
        check("ra_no_ack", ack_seen, 4'b0000);
        // rr_ptr=0 picks requester 1 over 2; last_domain=0 forces the gap
        run_op(1, 1'b1, 32'h9000, 32'h9100, 4'b0100, SW, 0);

`ifdef PLAB5_MCORE_DMA_SCHED_TIMEOUT_EN
        // Watchdog: no dma_ack, abort after 16 BUSY cycles
        @(negedge clk);
        bus.req_val = 4'b0100;
        bus.dma_rdy = 1'b1;
        wait_rdy(rdy);
        check("to_rdy", rdy, 4'b0100);
        @(negedge clk);
        bus.req_val = '0;
        #1;
        check("to_issue", bus.dma_val, 1'b1);
        @(negedge clk);
        #1;
        n = 0;
        while (bus.req_ack == '0 && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("to_cycles", n, TO);
        check("to_ack", bus.req_ack, 4'b0100);
        check("to_err", bus.req_err, 1'b1);
        @(negedge clk);
        #1;
        check("to_idle", busy, 1'b0);
        check("to_err_clr", bus.req_err, 1'b0);
`else
        // No watchdog: BUSY waits as long as the DMA takes
        @(negedge clk);
        bus.req_val = 4'b0100;
        bus.dma_rdy = 1'b1;
        wait_rdy(rdy);
        check("nt_rdy", rdy, 4'b0100);
        @(negedge clk);
        bus.req_val = '0;
        ack_seen    = '0;
        busy_all    = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            ack_seen |= bus.req_ack;
            busy_all &= busy;
        end
        check("nt_no_ack", ack_seen, 4'b0000);
        check("nt_busy", busy_all, 1'b1);
        @(negedge clk);
        bus.dma_ack = 1'b1;
        @(negedge clk);
        bus.dma_ack = 1'b0;
        #1;
        check("nt_ack", bus.req_ack, 4'b0100);
        check("nt_err", bus.req_err, 1'b0);
        @(negedge clk);
        #1;
        check("nt_idle", busy, 1'b0);
`endif
        // Normal operation afterwards (rr_ptr=3, last_domain=1)
        run_op(3, 1'b1, 32'hA000, 32'hB000, 4'b0000, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
